// File: rtl/fetch_sequencer_pkg.sv
// fetch_sequencer_pkg
//   Shared types and constants for the fetch sequencer: the FSM state
//   encoding, the MIPS opcode constants this block cares about, and a
//   helper that recognises an unconditional jump word.
package fetch_sequencer_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } fetch_state_e;

  localparam logic [5:0] J_OP   = 6'b000010;
  localparam logic [5:0] BEQ_OP = 6'b000100;
  localparam logic [5:0] LW_OP  = 6'b100011;
  localparam logic [5:0] SW_OP  = 6'b101011;

  function automatic logic is_jump(input logic [31:0] word);
    return word[31:26] == J_OP;
  endfunction

endpackage

// File: rtl/fetch_sequencer_fifo.sv
// fetch_fifo
//   Small synchronous instruction buffer holding {pc, word} entries.
//   Head is read combinationally from the storage array, so an entry written
//   at edge N is visible on dout right after edge N when the buffer was empty.
// Ports
//   clk, rst_n : clock, asynchronous active-low reset
//   push, pop  : write / read requests (pop ignored when empty, push ignored
//                when full unless a pop happens in the same cycle)
//   flush      : drop all entries; wins over push and pop
//   din, dout  : entry in, entry at head
//   count      : number of stored entries (log2(DEPTH)+1 bits)
//   empty, full: occupancy flags
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] rd_q;
  logic [PW-1:0] wr_q;
  logic [CW-1:0] cnt_q;
  logic          do_pop;
  logic          do_push;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CW'(DEPTH));
  assign do_pop  = pop & ~empty & ~flush;
  assign do_push = push & ~flush & (~full | do_pop);
  assign dout    = mem_q[rd_q];
  assign count   = cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (flush) begin
      // Collapse the write pointer onto the read pointer rather than zeroing
      // both, so the head word seen by decode does not change while empty.
      wr_q  <= rd_q;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= din;
        wr_q        <= wr_q + PW'(1);
      end
      if (do_pop) rd_q <= rd_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer
//   Program-counter sequencer for the single-cycle MIPS core. Drives the
//   word address of a combinational instruction ROM, buffers {pc, word}
//   pairs in fetch_fifo, and hands them to decode over valid/ready.
//   Unconditional jumps are folded here; execute can redirect the PC.
// Ports
//   clk, rst_n      : clock, asynchronous active-low reset
//   rom_addr        : ROM word address (equals the PC register)
//   rom_data        : ROM word at rom_addr, same cycle
//   halt            : stop fetching; the buffer keeps draining
//   redirect_valid  : flush the buffer and restart at redirect_pc
//   redirect_pc     : redirect target word address
//   instr_valid     : buffer head valid
//   instr_ready     : decode takes the head this cycle
//   instr, instr_pc : head word and its PC
//   busy            : FSM is not in S_IDLE
//   dbg_state       : current FSM state, for observation only
//
// Handshake: a head entry transfers on any rising edge where instr_valid
// and instr_ready are both 1 (pop); instr_valid never depends on
// instr_ready, and a redirect in the same cycle cancels the transfer.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter int                FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [31:0]       rom_data,
  input  logic              halt,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              busy,
  output fetch_state_e      dbg_state
);

  localparam int EW = ADDR_W + 32;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  // Low 26 bits come from the jump target; upper PC bits are kept.
  localparam logic [ADDR_W-1:0] JMASK = ADDR_W'(27'h3FF_FFFF);

  fetch_state_e      state_q;
  logic              busy_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;
  logic              pop;
  logic              fetch;
  logic [EW-1:0]     fifo_dout;
  logic [CW-1:0]     fifo_count;
  logic              fifo_empty;
  logic              fifo_full;

  assign pop   = instr_valid & instr_ready;
  assign fetch = (state_q == S_RUN) & ~redirect_valid & (~fifo_full | pop);

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fetch),
    .pop   (pop),
    .flush (redirect_valid),
    .din   ({pc_q, rom_data}),
    .dout  (fifo_dout),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  always_comb begin
    pc_d = pc_q;
    if (redirect_valid) begin
      pc_d = redirect_pc;
    end else if (fetch) begin
      if (is_jump(rom_data)) pc_d = (pc_q & ~JMASK) | (ADDR_W'(rom_data[25:0]) & JMASK);
      else                   pc_d = pc_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_q <= RESET_PC;
    else        pc_q <= pc_d;
  end

  // Redirect never changes the state; busy is registered with the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_q <= S_RUN;
          busy_q  <= 1'b1;
        end
        S_RUN: begin
          if (halt) state_q <= S_HALT;
          busy_q <= 1'b1;
        end
        S_HALT: begin
          if (!halt) state_q <= S_RUN;
          busy_q <= 1'b1;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign rom_addr    = pc_q;
  assign instr_valid = ~fifo_empty;
  assign instr       = fifo_dout[31:0];
  assign instr_pc    = fifo_dout[EW-1:32];
  assign busy        = busy_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer
//   Directed scenarios followed by a randomized phase. A queue-based
//   reference model of the sequencer predicts rom_addr, the buffer head and
//   busy after every edge; the ROM is a small function of the address.
module tb_fetch_sequencer;
  import fetch_sequencer_pkg::*;

  localparam int DEPTH = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [31:0]  rom_addr;
  logic [31:0]  rom_data;
  logic         halt = 1'b0;
  logic         redirect_valid = 1'b0;
  logic [31:0]  redirect_pc = '0;
  logic         instr_valid;
  logic         instr_ready = 1'b0;
  logic [31:0]  instr;
  logic [31:0]  instr_pc;
  logic         busy;
  fetch_state_e dbg_state;

  fetch_sequencer #(
    .ADDR_W     (32),
    .RESET_PC   (32'h0),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .halt           (halt),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .busy           (busy),
    .dbg_state      (dbg_state)
  );

  // Instruction ROM: 0: j 4; 4: sub; 5: sw; default lw.
  // One extra jump in a high bank checks that upper PC bits survive a jump.
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h0800_0004;
      32'h0000_0004: return 32'h0043_1022;
      32'h0000_0005: return 32'hAC02_0000;
      32'h0400_0000: return 32'h0800_0002;
      default:       return 32'h8C02_0000;
    endcase
  endfunction

  assign rom_data = rom_word(rom_addr);

  // ---------------- reference model ----------------
  logic [63:0] exp_q[$];     // {pc, word} entries in buffer order
  logic [31:0] pc_m;
  bit          started_m;    // at least one edge since reset
  bit          halted_m;     // fetch suppressed by halt seen at last edge
  logic [31:0] seen_q[$];    // PCs decode accepted from the DUT

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    pc_m      = 32'h0;
    started_m = 1'b0;
    halted_m  = 1'b0;
  endtask

  task automatic model_step(input bit r, input bit h, input bit rv, input logic [31:0] rp);
    bit          do_pop;
    bit          do_fetch;
    logic [31:0] w;
    do_pop = (exp_q.size() > 0) && r;
    if (rv) begin
      exp_q.delete();
      pc_m = rp;
    end else begin
      do_fetch = started_m && !halted_m && ((exp_q.size() < DEPTH) || do_pop);
      if (do_pop) void'(exp_q.pop_front());
      if (do_fetch) begin
        w = rom_word(pc_m);
        exp_q.push_back({pc_m, w});
        if (w[31:26] == 6'b000010) pc_m = {pc_m[31:26], w[25:0]};
        else                       pc_m = pc_m + 32'd1;
      end
    end
    halted_m  = started_m ? h : 1'b0;
    started_m = 1'b1;
  endtask

  task automatic check_model();
    chk("rom_addr", rom_addr, pc_m);
    chk("instr_valid", instr_valid, exp_q.size() > 0);
    chk("busy", busy, started_m);
    if (exp_q.size() > 0) begin
      chk("instr_pc", instr_pc, exp_q[0][63:32]);
      chk("instr", instr, exp_q[0][31:0]);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called at a falling edge: drive inputs, step through one rising edge,
  // then compare at the next falling edge.
  task automatic cycle(input bit r, input bit h, input bit rv, input logic [31:0] rp);
    instr_ready    = r;
    halt           = h;
    redirect_valid = rv;
    redirect_pc    = rp;
    if (instr_valid && r) seen_q.push_back(instr_pc);
    @(posedge clk);
    model_step(r, h, rv, rp);
    @(negedge clk);
    check_model();
  endtask

  // Reset asserted between edges; its effect must be visible without a clock.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_instr_valid", instr_valid, 1'b0);
    chk("rst_rom_addr", rom_addr, 32'h0);
    chk("rst_busy", busy, 1'b0);
    model_reset();
    instr_ready    = 1'b0;
    halt           = 1'b0;
    redirect_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_model();
    chk("rst_instr", instr, 32'h0);
    chk("rst_instr_pc", instr_pc, 32'h0);
  endtask

  task automatic run_boot_sequence(input string tag);
    logic [31:0] want[4];
    want[0] = 32'h0; want[1] = 32'h4; want[2] = 32'h5; want[3] = 32'h6;
    seen_q.delete();
    for (int i = 0; i < 7; i++) cycle(1'b1, 1'b0, 1'b0, 32'h0);
    chk({tag, "_pop_count"}, seen_q.size() >= 4, 1'b1);
    for (int i = 0; i < 4; i++)
      if (i < seen_q.size()) chk({tag, "_pc_seq"}, seen_q[i], want[i]);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] rp;
    bit          h;

    // 1. boot sequence 0 (j), 4, 5, 6
    do_reset();
    run_boot_sequence("t1");

    // 2. decode stalled: buffer fills with 0 and 4, PC holds at 5
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b0, 32'h0);
    chk("t2_rom_addr_hold", rom_addr, 32'h5);
    chk("t2_head", instr_pc, 32'h0);
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    chk("t2_head_after_pop", instr_pc, 32'h4);
    chk("t2_rom_addr_push", rom_addr, 32'h6);

    // 3. redirect with a full buffer
    cycle(1'b0, 1'b0, 1'b1, 32'h10);
    chk("t3_valid_flushed", instr_valid, 1'b0);
    chk("t3_rom_addr", rom_addr, 32'h10);
    cycle(1'b0, 1'b0, 1'b0, 32'h0);
    chk("t3_head", instr_pc, 32'h10);

    // 4. halt raised while PC = 5
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 32'h0);
    chk("t4_pc_before_halt", rom_addr, 32'h5);
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    chk("t4_last_push", rom_addr, 32'h6);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 32'h0);
    chk("t4_drained", instr_valid, 1'b0);
    chk("t4_pc_held", rom_addr, 32'h6);
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    chk("t4_resume_head", instr_pc, 32'h6);

    // 5. PC wrap
    cycle(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF);
    seen_q.delete();
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 32'h0);
    chk("t5_pop_count", seen_q.size() >= 2, 1'b1);
    if (seen_q.size() >= 2) begin
      chk("t5_pc_top", seen_q[0], 32'hFFFF_FFFF);
      chk("t5_pc_wrapped", seen_q[1], 32'h0);
    end

    // 6. reset mid-stream with a full buffer, then reboot
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b0, 32'h0);
    chk("t6_full_valid", instr_valid, 1'b1);
    do_reset();
    run_boot_sequence("t6");

    // jump in a high bank keeps the upper PC bits
    cycle(1'b1, 1'b0, 1'b1, 32'h0400_0000);
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    chk("hi_jump_target", rom_addr, 32'h0400_0002);

    // randomized phase
    h = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 7) == 0) h = ~h;
      case ($urandom_range(0, 7))
        0: rp = 32'h0;
        1: rp = 32'h4;
        2: rp = 32'h5;
        3: rp = 32'hFFFF_FFFE;
        4: rp = 32'h0400_0000;
        5: rp = 32'h10;
        default: rp = $urandom;
      endcase
      if ($urandom_range(0, 199) == 0) do_reset();
      else cycle($urandom_range(0, 3) != 0, h, $urandom_range(0, 11) == 0, rp);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
